// File: rtl/div_ctrl.sv
// Sequencing controller for the RV32M divide unit: operand sign handling, core launch,
// sign fix-up, special cases and tagged valid/ready response. Optional: DIV_CTRL_REUSE_EN.
module div_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             core_start,
    output logic [XLEN-1:0]  core_dividend,
    output logic [XLEN-1:0]  core_divisor,
    input  logic             core_done,
    input  logic [XLEN-1:0]  core_quotient,
    input  logic [XLEN-1:0]  core_remainder
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } state_e;

    localparam logic [XLEN-1:0] One    = XLEN'(1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + One;
    endfunction

    state_e             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               sel_rem_q, sel_rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    dividend_q, dividend_d;
    logic [XLEN-1:0]    divisor_q, divisor_d;
    logic [XLEN-1:0]    resp_data_q, resp_data_d;

    logic               s1_in, s2_in;
    logic [XLEN-1:0]    mag1, mag2;
    logic               div_zero, sgn_ovf;
    logic [XLEN-1:0]    special_res;
    logic [XLEN-1:0]    quo_fix, rem_fix;

`ifdef DIV_CTRL_REUSE_EN
    logic               op0_q, op0_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    rs2_q, rs2_d;
    logic               reuse_valid_q, reuse_valid_d;
    logic               reuse_op0_q, reuse_op0_d;
    logic [XLEN-1:0]    reuse_rs1_q, reuse_rs1_d;
    logic [XLEN-1:0]    reuse_rs2_q, reuse_rs2_d;
    logic [XLEN-1:0]    reuse_quo_q, reuse_quo_d;
    logic [XLEN-1:0]    reuse_rem_q, reuse_rem_d;
    logic               reuse_hit;
`endif

    // Operand conditioning for an incoming request; only meaningful while idle.
    always_comb begin
        s1_in    = req_rs1[XLEN-1] & ~req_op[0];
        s2_in    = req_rs2[XLEN-1] & ~req_op[0];
        mag1     = s1_in ? negate(req_rs1) : req_rs1;
        mag2     = s2_in ? negate(req_rs2) : req_rs2;
        div_zero = (req_rs2 == '0);
        sgn_ovf  = ~req_op[0] && (req_rs1 == MinNeg) && (req_rs2 == '1);
        if (div_zero) begin
            special_res = req_op[1] ? req_rs1 : '1;
        end else begin
            special_res = req_op[1] ? '0 : req_rs1;
        end
    end

    always_comb begin
        quo_fix = (s1_q ^ s2_q) ? negate(core_quotient) : core_quotient;
        rem_fix = s1_q ? negate(core_remainder) : core_remainder;
    end

`ifdef DIV_CTRL_REUSE_EN
    assign reuse_hit = reuse_valid_q && (reuse_rs1_q == req_rs1) && (reuse_rs2_q == req_rs2)
                       && (reuse_op0_q == req_op[0]);
`endif

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        sel_rem_d   = sel_rem_q;
        tag_d       = tag_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        resp_data_d = resp_data_q;
`ifdef DIV_CTRL_REUSE_EN
        op0_d         = op0_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        reuse_valid_d = reuse_valid_q;
        reuse_op0_d   = reuse_op0_q;
        reuse_rs1_d   = reuse_rs1_q;
        reuse_rs2_d   = reuse_rs2_q;
        reuse_quo_d   = reuse_quo_q;
        reuse_rem_d   = reuse_rem_q;
`endif

        case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    tag_d     = req_tag;
                    sel_rem_d = req_op[1];
                    s1_d      = s1_in;
                    s2_d      = s2_in;
`ifdef DIV_CTRL_REUSE_EN
                    op0_d     = req_op[0];
                    rs1_d     = req_rs1;
                    rs2_d     = req_rs2;
`endif
                    if (div_zero || sgn_ovf) begin
                        resp_data_d = special_res;
                        state_d     = StResp;
                    end
`ifdef DIV_CTRL_REUSE_EN
                    else if (reuse_hit) begin
                        resp_data_d = req_op[1] ? reuse_rem_q : reuse_quo_q;
                        state_d     = StResp;
                    end
`endif
                    else begin
                        dividend_d = mag1;
                        divisor_d  = mag2;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                // The start pulse still goes out on a flush; DRAIN absorbs its done.
                state_d = flush ? StDrain : StWait;
            end
            StWait: begin
                if (flush) begin
                    state_d = core_done ? StIdle : StDrain;
                end else if (core_done) begin
                    resp_data_d = sel_rem_q ? rem_fix : quo_fix;
                    state_d     = StResp;
`ifdef DIV_CTRL_REUSE_EN
                    reuse_valid_d = 1'b1;
                    reuse_op0_d   = op0_q;
                    reuse_rs1_d   = rs1_q;
                    reuse_rs2_d   = rs2_q;
                    reuse_quo_d   = quo_fix;
                    reuse_rem_d   = rem_fix;
`endif
                end
            end
            StResp: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (core_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            sel_rem_q   <= 1'b0;
            tag_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            resp_data_q <= '0;
`ifdef DIV_CTRL_REUSE_EN
            op0_q         <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            reuse_valid_q <= 1'b0;
            reuse_op0_q   <= 1'b0;
            reuse_rs1_q   <= '0;
            reuse_rs2_q   <= '0;
            reuse_quo_q   <= '0;
            reuse_rem_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            sel_rem_q   <= sel_rem_d;
            tag_q       <= tag_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            resp_data_q <= resp_data_d;
`ifdef DIV_CTRL_REUSE_EN
            op0_q         <= op0_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            reuse_valid_q <= reuse_valid_d;
            reuse_op0_q   <= reuse_op0_d;
            reuse_rs1_q   <= reuse_rs1_d;
            reuse_rs2_q   <= reuse_rs2_d;
            reuse_quo_q   <= reuse_quo_d;
            reuse_rem_q   <= reuse_rem_d;
`endif
        end
    end

    assign req_ready     = (state_q == StIdle) && rst_n;
    assign busy          = (state_q != StIdle);
    assign core_start    = (state_q == StIssue);
    assign resp_valid    = (state_q == StResp);
    assign resp_data     = resp_data_q;
    assign resp_tag      = tag_q;
    assign core_dividend = dividend_q;
    assign core_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative-core stand-in of programmable latency.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;
    logic        core_start;
    logic [31:0] core_dividend, core_divisor;
    logic        core_done;
    logic [31:0] core_quotient, core_remainder;

    int checks = 0;
    int errors = 0;
    int core_lat = 1;
    int cnt;

    div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_tag       (req_tag),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .busy          (busy),
        .core_start    (core_start),
        .core_dividend (core_dividend),
        .core_divisor  (core_divisor),
        .core_done     (core_done),
        .core_quotient (core_quotient),
        .core_remainder(core_remainder)
    );

    always #5 clk = ~clk;

    // Unsigned core stand-in: done pulses core_lat edges after start is sampled.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (!rst_n) begin
            cnt            <= 0;
            core_quotient  <= '0;
            core_remainder <= '0;
        end else if (core_start) begin
            cnt <= core_lat;
            if (core_divisor == 0) begin
                core_quotient  <= '1;
                core_remainder <= core_dividend;
            end else begin
                core_quotient  <= core_dividend / core_divisor;
                core_remainder <= core_dividend % core_divisor;
            end
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) core_done <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and collect its response; lat counts edges from acceptance.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] data,
                          output logic [4:0] rtag, output int lat, output int starts,
                          output bit timeout);
        int w;
        timeout = 1'b0;
        starts  = 0;
        w = 0;
        while (!req_ready && w < 40) begin
            tick();
            w++;
        end
        req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
        req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            if (core_start) starts++;
            tick();
            lat++;
        end
        if (!resp_valid) timeout = 1'b1;
        data = resp_data;
        rtag = resp_tag;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready);
        end
        checks++;
        if ({resp_valid, core_start, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {resp_valid, core_start, busy});
        end
        checks++;
        if ({resp_data, resp_tag, core_dividend, core_divisor} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", resp_data, resp_tag,
                               core_dividend, core_divisor);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [4:0] t; int lat, st; bit to;
        run_op(2'b00, 32'd11, 32'd3, 5'd4, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd3 || st != 1) begin
            errors++; $display("FAIL div_11_3 got %h starts %0d to %0d exp 3 starts 1", d, st, to);
        end
        run_op(2'b10, 32'd11, 32'd3, 5'd5, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd2 || t !== 5'd5) begin
            errors++; $display("FAIL rem_11_3 got %h tag %0d exp 2 tag 5", d, t);
        end
`ifdef DIV_CTRL_REUSE_EN
        checks++;
        if (st != 0 || lat != 1) begin
            errors++; $display("FAIL rem_reuse got starts %0d lat %0d exp 0 1", st, lat);
        end
`else
        checks++;
        if (st != 1) begin
            errors++; $display("FAIL rem_start got %0d exp 1", st);
        end
`endif
    endtask

    task automatic test_signed();
        logic [31:0] d; logic [4:0] t; int lat, st; bit to;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_m7_2 got %h exp fffffffd", d);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rem_m7_2 got %h exp ffffffff", d);
        end
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd3, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'h7FFF_FFFC) begin
            errors++; $display("FAIL divu_fff9_2 got %h exp 7ffffffc", d);
        end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd4, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd1) begin
            errors++; $display("FAIL remu_fff9_2 got %h exp 1", d);
        end
    endtask

    task automatic test_special();
        logic [31:0] d; logic [4:0] t; int lat, st; bit to;
        run_op(2'b00, 32'h1234, 32'd0, 5'd6, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'hFFFF_FFFF || lat != 1 || st != 0 || t !== 5'd6) begin
            errors++; $display("FAIL div_by_zero got %h lat %0d starts %0d exp ffffffff 1 0",
                               d, lat, st);
        end
        run_op(2'b11, 32'h1234, 32'd0, 5'd7, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'h1234 || lat != 1 || st != 0) begin
            errors++; $display("FAIL remu_by_zero got %h lat %0d starts %0d exp 1234 1 0",
                               d, lat, st);
        end
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'h8000_0000 || lat != 1 || st != 0) begin
            errors++; $display("FAIL div_ovf got %h lat %0d starts %0d exp 80000000 1 0",
                               d, lat, st);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd0 || lat != 1 || st != 0) begin
            errors++; $display("FAIL rem_ovf got %h lat %0d starts %0d exp 0 1 0", d, lat, st);
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] d; logic [4:0] t; int lat, st; bit to;
        bit done_seen, rv_seen, ready_seen;
        core_lat = 3;
        req_op = 2'b00; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'd10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        done_seen = 1'b0; rv_seen = 1'b0; ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) rv_seen = 1'b1;
            if (req_ready) begin
                ready_seen = 1'b1;
                break;
            end
            if (core_done) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (rv_seen) begin
            errors++; $display("FAIL flush_no_resp got resp_valid 1 exp 0");
        end
        checks++;
        if (!ready_seen || !done_seen) begin
            errors++; $display("FAIL flush_drain got ready %0d done_before %0d exp 1 1",
                               ready_seen, done_seen);
        end
        core_lat = 1;
        run_op(2'b00, 32'd100, 32'd7, 5'd11, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd14 || t !== 5'd11) begin
            errors++; $display("FAIL after_flush got %h tag %0d exp 0000000e tag 11", d, t);
        end
    endtask

    task automatic test_flush_resp();
        req_op = 2'b00; req_rs1 = 32'd3; req_rs2 = 32'd0; req_tag = 5'd12;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        resp_ready = 1'b1;
        tick();
        flush = 1'b0;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_resp got valid %b busy %b exp 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        bit stable;
        req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd9; req_tag = 5'd21;
        req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (!resp_valid) begin
            errors++; $display("FAIL bp_timeout got resp_valid 0 exp 1");
        end
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (resp_data !== 32'd111 || resp_tag !== 5'd21 || req_ready || !resp_valid)
                stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable || resp_data !== 32'd111) begin
            errors++; $display("FAIL bp_hold got %h tag %0d exp 0000006f tag 21",
                               resp_data, resp_tag);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid %b ready %b exp 0 1",
                               resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic [4:0] t; int lat, st; bit to;
        core_lat = 5;
        req_op = 2'b00; req_rs1 = 32'd77; req_rs2 = 32'd7; req_tag = 5'd13;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({resp_valid, core_start, busy} !== 3'b000 ||
            {resp_data, resp_tag, core_dividend, core_divisor} !== '0) begin
            errors++; $display("FAIL midop_reset got %b %h %h %h exp all 0",
                               {resp_valid, core_start, busy}, resp_data, core_dividend,
                               core_divisor);
        end
        rst_n = 1'b1;
        core_lat = 1;
        #1;
        run_op(2'b00, 32'd100, 32'd7, 5'd14, d, t, lat, st, to);
        checks++;
        if (to || d !== 32'd14 || t !== 5'd14) begin
            errors++; $display("FAIL midop_after got %h tag %0d exp 0000000e tag 14", d, t);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_special();
        test_flush_wait();
        test_flush_resp();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the RV32M divide unit. Sits between the EX stage and the iterative unsigned divider core (the non-restoring array). It accepts DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes. It launches the core with a one-cycle start pulse, waits for the core's done, and applies sign fix-up. Divide-by-zero and signed overflow are resolved without using the core. A valid/ready response is returned to the pipeline with the instruction tag.

## Interface
- `XLEN`, 32, operand/result width
- `TAG_W`, 5, destination tag width (rd)

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; `(state==IDLE) && rst_n`
- `req_op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_rs1`, `req_rs2`  in  XLEN  dividend, divisor
- `req_tag`  in  TAG_W  tag echoed on response
- `flush`  in  1  kill in-flight operation
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_data`  out  XLEN  quotient or remainder
- `resp_tag`  out  TAG_W  tag of result
- `busy`  out  1  `state != IDLE`
- `core_start`  out  1  one-cycle launch pulse to core
- `core_dividend`, `core_divisor`  out  XLEN  unsigned magnitudes to core, held from launch until done
- `core_done`  in  1  core result valid, single-cycle pulse
- `core_quotient`, `core_remainder`  in  XLEN  unsigned core results

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE, on `req_valid && req_ready && !flush`:
  - latch op, tag, and signs `s1 = rs1[XLEN-1] & ~op[0]` and `s2 = rs2[XLEN-1] & ~op[0]`.
  - Magnitudes: `|x| = s ? (~x + 1) : x`, XLEN bits, no extension. 0x80000000 maps to 0x80000000.
- Special cases resolved in IDLE go directly to RESP, and the core is not started:
  - rs2 == 0: quotient = all ones; remainder = rs1 unmodified.
  - signed op, rs1 == 1<<(XLEN-1) and rs2 == all ones: quotient = rs1; remainder = 0.
- All other requests go IDLE→ISSUE.
  - ISSUE: `core_start=1` and magnitudes driven; then →WAIT.
- WAIT, on `core_done`:
  - quotient = `(s1^s2) ? -core_quotient : core_quotient`.
  - remainder = `s1 ? -core_remainder : core_remainder`.
  - Select per op[1], register into `resp_data`, then →RESP.
- RESP: `resp_valid=1`, with data and tag stable. On `resp_ready`, →IDLE.
- Flush:
  - IDLE: request not accepted (flush wins over a simultaneous `req_valid`).
  - ISSUE/WAIT: →DRAIN. The core cannot be aborted.
  - DRAIN: ignores requests; `core_done` is discarded, then →IDLE. A `core_done` in the flush cycle itself is discarded, then →IDLE directly.
  - RESP: `resp_valid` drops next cycle, →IDLE; the result is lost even if `resp_ready` was high in the same cycle.
- `core_done` outside WAIT/DRAIN is ignored.

## Timing
- Reset (`rst_n` low at edge): state=IDLE. `resp_valid`, `resp_data`, `resp_tag`, `core_start`, `core_dividend`, `core_divisor` all 0. Reuse entry invalid.
- Acceptance at edge E0:
  - special case: `resp_valid` high after E0 (latency 1).
  - normal: `core_start` high in the cycle after E0.
- If `core_done` is sampled at edge Ek, `resp_valid` is high after Ek. Total latency = core latency + 2.
- Back-to-back: `req_ready` rises the cycle after the response handshake. Maximum one op in flight.
- `resp_data`/`resp_tag` hold while `resp_valid && !resp_ready`.
- Reset mid-operation returns to IDLE immediately; the core must be reset by the same `rst_n`.

## Configuration
- `DIV_CTRL_REUSE_EN` defined:
  - One-entry reuse register holds rs1, rs2, op[0], final quotient and final remainder. It is filled only on a WAIT completion and is not filled from DRAIN.
  - A request with a hit (valid entry, equal rs1, rs2 and op[0]) goes IDLE→RESP with the stored value per op[1]. Latency is 1 and the core is not started.
  - Flush does not invalidate the entry.
- `DIV_CTRL_REUSE_EN` undefined: no reuse storage; every non-special request goes through the core.

## Test plan
- DIV 11/3, then REM 11/3 (tag 5) → `resp_data` 3 then 2, `resp_tag`=5, each `core_start` exactly 1 cycle. With the macro defined, the REM hits, responds in 1 cycle, and no `core_start` is issued.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- DIV 0x1234/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, both one cycle after acceptance. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. No `core_start` in any of these cases.
- Flush asserted in WAIT, with `core_done` 3 cycles later: no `resp_valid`, `req_ready` stays 0 until done, the next request returns correct data.
- `resp_ready` held low for 4 cycles in RESP → data and tag stable, `req_ready`=0. Release → handshake, and `req_ready`=1 the next cycle.
- `rst_n` low for one edge during WAIT → all outputs 0 next cycle, state IDLE, and a new DIV 100/7 returns 14.
